// File: rtl/wb_cnt_pkg.sv
// Shared definitions for the Wishbone counter slave: register offsets, bit
// positions and the byte-lane merge used for masked register writes.
package wb_cnt_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_STATUS = 2'd2,
        REG_LIMIT  = 2'd3
    } regSel_e;

    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_COUNT  = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;
    localparam logic [3:0] OFS_LIMIT  = 4'hC;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_UP  = 1;
    localparam int CTRL_IRQ = 2;

    localparam int ST_SAT_HI = 0;
    localparam int ST_SAT_LO = 1;
    localparam int ST_MATCH  = 2;

    localparam logic [2:0] STATUS_RST = 3'b000;

    // Replaces only the byte lanes whose enable is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_counter_slave_if.sv
// Wishbone B4 classic bus bundle between a master and the counter slave.
interface wb_counter_slave_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_slave_if.sv
// Wishbone handshake: request detect, one-cycle ack and registered read data
// captured from register contents as they were before the acking edge.
module wb_slave_if
    import wb_cnt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    wb_counter_slave_if.slave bus,
    input  logic [31:0]       rdCtrl_i,
    input  logic [31:0]       rdCount_i,
    input  logic [31:0]       rdStatus_i,
    input  logic [31:0]       rdLimit_i,
    output logic              req_o
);

    logic        ack_q;
    logic [31:0] rdData_q;
    logic [31:0] rdMux;

    // Masking with ack_q forces a wait state and spaces back-to-back requests.
    assign req_o = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;

    always_comb begin
        rdMux = rdCtrl_i;
        case (regSel_e'(bus.wb_adr_i[3:2]))
            REG_CTRL:   rdMux = rdCtrl_i;
            REG_COUNT:  rdMux = rdCount_i;
            REG_STATUS: rdMux = rdStatus_i;
            REG_LIMIT:  rdMux = rdLimit_i;
            default:    rdMux = rdCtrl_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            rdData_q <= '0;
        end else begin
            ack_q <= req_o;
            if (req_o && !bus.wb_we_i) begin
                rdData_q <= rdMux;
            end
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = rdData_q;

endmodule

// File: rtl/wb_counter_slave.sv
// Memory-mapped saturating up/down counter with sticky W1C status bits.
// Define WB_CNT_IRQ_EN to build the registered level interrupt and CTRL.irq_en.
module wb_counter_slave
    import wb_cnt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_counter_slave_if.slave bus,
    output logic              irq_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             req;
    regSel_e          regSel;
    logic             ctrlWr, countWr, statusWr, limitWr;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [2:0]       status_q, status_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [31:0]      countWrVal, limitWrVal;
    logic             satHiSet, satLoSet, matchSet, countStep;
    logic [1:0]       unusedAdr;

    assign unusedAdr = bus.wb_adr_i[1:0];

    wb_slave_if u_handshake (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rdCtrl_i   (32'(ctrl_q)),
        .rdCount_i  (32'(count_q)),
        .rdStatus_i (32'(status_q)),
        .rdLimit_i  (32'(limit_q)),
        .req_o      (req)
    );

    // Single-byte registers only react when lane 0 is enabled.
    always_comb begin
        regSel     = regSel_e'(bus.wb_adr_i[3:2]);
        ctrlWr     = req && bus.wb_we_i && (regSel == REG_CTRL)   && bus.wb_sel_i[0];
        countWr    = req && bus.wb_we_i && (regSel == REG_COUNT)  && (|bus.wb_sel_i);
        statusWr   = req && bus.wb_we_i && (regSel == REG_STATUS) && bus.wb_sel_i[0];
        limitWr    = req && bus.wb_we_i && (regSel == REG_LIMIT)  && (|bus.wb_sel_i);
        countWrVal = mergeBytes(32'(count_q), bus.wb_dat_i, bus.wb_sel_i);
        limitWrVal = mergeBytes(32'(limit_q), bus.wb_dat_i, bus.wb_sel_i);
    end

    // A software load takes priority over counting on the same edge.
    always_comb begin
        count_d   = count_q;
        satHiSet  = 1'b0;
        satLoSet  = 1'b0;
        countStep = 1'b0;
        if (countWr) begin
            count_d   = countWrVal[WIDTH-1:0];
            countStep = 1'b1;
        end else if (ctrl_q[CTRL_EN]) begin
            countStep = 1'b1;
            if (ctrl_q[CTRL_UP]) begin
                if (count_q == CNT_MAX) satHiSet = 1'b1;
                else                    count_d  = count_q + 1'b1;
            end else begin
                if (count_q == '0) satLoSet = 1'b1;
                else               count_d  = count_q - 1'b1;
            end
        end
        matchSet = countStep && (count_d == limit_q);
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrlWr) begin
            ctrl_d[CTRL_EN] = bus.wb_dat_i[CTRL_EN];
            ctrl_d[CTRL_UP] = bus.wb_dat_i[CTRL_UP];
`ifdef WB_CNT_IRQ_EN
            ctrl_d[CTRL_IRQ] = bus.wb_dat_i[CTRL_IRQ];
`endif
        end
        // Set terms are OR-ed after the clear so a new event survives a W1C.
        status_d = (status_q & ~(statusWr ? bus.wb_dat_i[2:0] : 3'b000))
                 | {matchSet, satLoSet, satHiSet};
        limit_d  = limitWr ? limitWrVal[WIDTH-1:0] : limit_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            status_q <= STATUS_RST;
            limit_q  <= '1;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            status_q <= status_d;
            limit_q  <= limit_d;
        end
    end

`ifdef WB_CNT_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= ctrl_q[CTRL_IRQ] & (|status_q);
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_counter_slave.sv
// Scoreboard bench for wb_counter_slave: directed scenarios plus random bus
// traffic checked against a cycle-level arithmetic model of the register map.
module tb_wb_counter_slave;
    import wb_cnt_pkg::*;

    localparam int     WIDTH = 32;
    localparam longint MAXV  = (64'd1 << WIDTH) - 1;
`ifdef WB_CNT_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    wb_counter_slave_if bus ();

    wb_counter_slave #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sbQ[$];

    bit [2:0]    mCtrl, mStatus, nCtrl, setBits, clrBits;
    longint      mCount, mLimit, nCount, nLimit;
    bit          mAck, mIrq, mReq, loaded;
    int          edgeCnt = 0;
    logic [31:0] merged;

    function automatic logic [31:0] byteWrite(input logic [31:0] oldV, input logic [31:0] newV,
                                              input logic [3:0] sel);
        logic [31:0] r;
        r = oldV;
        if (sel[0]) r[7:0]   = newV[7:0];
        if (sel[1]) r[15:8]  = newV[15:8];
        if (sel[2]) r[23:16] = newV[23:16];
        if (sel[3]) r[31:24] = newV[31:24];
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [3:0] adr);
        case (adr[3:2])
            2'd0:    return {29'd0, mCtrl};
            2'd1:    return mCount[31:0];
            2'd2:    return {29'd0, mStatus};
            default: return mLimit[31:0];
        endcase
    endfunction

    // Reference model: register map evaluated once per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCtrl = 0; mStatus = 0; mCount = 0; mLimit = MAXV;
            mAck = 0; mIrq = 0;
            sbQ.delete();
        end else begin
            edgeCnt++;
            mReq    = bus.wb_cyc_i && bus.wb_stb_i && !mAck;
            nCtrl   = mCtrl;
            nCount  = mCount;
            nLimit  = mLimit;
            setBits = 0;
            clrBits = 0;
            loaded  = 0;
            if (mReq) begin
                sbQ.push_back('{!bus.wb_we_i, modelRead(bus.wb_adr_i), edgeCnt});
                if (bus.wb_we_i) begin
                    case (bus.wb_adr_i[3:2])
                        2'd0: if (bus.wb_sel_i[0])
                                  nCtrl = {IRQ_BUILD & bus.wb_dat_i[2], bus.wb_dat_i[1:0]};
                        2'd1: if (bus.wb_sel_i != 0) begin
                                  merged = byteWrite(mCount[31:0], bus.wb_dat_i, bus.wb_sel_i);
                                  nCount = merged;
                                  loaded = 1;
                              end
                        2'd2: if (bus.wb_sel_i[0]) clrBits = bus.wb_dat_i[2:0];
                        default: if (bus.wb_sel_i != 0) begin
                                  merged = byteWrite(mLimit[31:0], bus.wb_dat_i, bus.wb_sel_i);
                                  nLimit = merged;
                              end
                    endcase
                end
            end
            if (!loaded && mCtrl[0]) begin
                nCount = mCount + (mCtrl[1] ? 1 : -1);
                if (nCount > MAXV) begin nCount = MAXV; setBits[0] = 1; end
                if (nCount < 0)    begin nCount = 0;    setBits[1] = 1; end
            end
            if ((loaded || mCtrl[0]) && nCount == mLimit) setBits[2] = 1;
            mIrq    = IRQ_BUILD && mCtrl[2] && (mStatus != 0);
            mStatus = (mStatus & ~clrBits) | setBits;
            mCtrl   = nCtrl;
            mCount  = nCount;
            mLimit  = nLimit;
            mAck    = mReq;
        end
    end

    // Monitor: pops the scoreboard whenever the slave acknowledges.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (irq !== mIrq) begin
                bad++;
                $display("[TB] FAIL irq_level: got %b expected %b at edge %0d", irq, mIrq, edgeCnt);
            end
            if (bus.wb_ack_o === 1'b1) begin
                total++;
                if (sbQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_ack: got ack expected none at edge %0d", edgeCnt);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    if (e.due != edgeCnt) begin
                        bad++;
                        $display("[TB] FAIL ack_timing: got edge %0d expected edge %0d", edgeCnt, e.due);
                    end else if (e.isRead && bus.wb_dat_o !== e.data) begin
                        bad++;
                        $display("[TB] FAIL read_data: got %h expected %h", bus.wb_dat_o, e.data);
                    end
                end
            end else if (sbQ.size() > 0 && sbQ[0].due < edgeCnt) begin
                total++;
                bad++;
                $display("[TB] FAIL missing_ack: got none expected ack at edge %0d", sbQ[0].due);
                void'(sbQ.pop_front());
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input bit dropEarly,
                                 output logic [31:0] rdata);
        bit got;
        got   = 0;
        rdata = '0;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
        bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        @(posedge clk); #1;
        if (dropEarly) begin bus.wb_cyc_i = 0; bus.wb_stb_i = 0; end
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o === 1'b1) begin got = 1; rdata = bus.wb_dat_o; end
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL ack_wait: got no ack expected ack within 4 cycles");
        end
        @(posedge clk); #1;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] unusedRd;
        applyStimulus(1'b1, adr, dat, 4'hF, 1'b0, unusedRd);
    endtask

    task automatic rdCheck(input string name, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        applyStimulus(1'b0, adr, 32'h0, 4'h0, 1'b0, r);
        checkOutput(name, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] dat;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
        rst_n = 0;
        #23 rst_n = 1;
        checkOutput("reset_ack", 32'(bus.wb_ack_o), 32'h0);
        checkOutput("reset_dat", bus.wb_dat_o, 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        @(posedge clk); #1;

        $display("[TB] reset values");
        rdCheck("rst_ctrl",   OFS_CTRL,   32'h0);
        rdCheck("rst_count",  OFS_COUNT,  32'h0);
        rdCheck("rst_status", OFS_STATUS, 32'h0);
        rdCheck("rst_limit",  OFS_LIMIT,  32'hFFFF_FFFF);

        $display("[TB] count up ten");
        wr(OFS_CTRL, 32'h3);
        idle(8);
        wr(OFS_CTRL, 32'h0);
        rdCheck("count_ten", OFS_COUNT, 32'd10);

        $display("[TB] saturate high");
        wr(OFS_LIMIT, 32'h1234);
        wr(OFS_COUNT, 32'hFFFF_FFFE);
        wr(OFS_CTRL, 32'h3);
        idle(2);
        rdCheck("sat_hi_count", OFS_COUNT, 32'hFFFF_FFFF);
        rdCheck("sat_hi_status", OFS_STATUS, 32'h1);
        wr(OFS_STATUS, 32'h1);
        rdCheck("set_beats_clear", OFS_STATUS, 32'h1);

        $display("[TB] saturate low");
        wr(OFS_CTRL, 32'h0);
        wr(OFS_STATUS, 32'h7);
        wr(OFS_COUNT, 32'h1);
        wr(OFS_CTRL, 32'h1);
        idle(2);
        rdCheck("sat_lo_count", OFS_COUNT, 32'h0);
        rdCheck("sat_lo_status", OFS_STATUS, 32'h2);
        wr(OFS_CTRL, 32'h0);
        wr(OFS_STATUS, 32'h2);
        rdCheck("w1c_status", OFS_STATUS, 32'h0);

        $display("[TB] compare match");
        wr(OFS_LIMIT, 32'd5);
        wr(OFS_COUNT, 32'd0);
        wr(OFS_CTRL, 32'h7);
        idle(3);
        wr(OFS_CTRL, 32'h4);
        checkOutput("irq_on_match", 32'(irq), 32'(IRQ_BUILD));
        rdCheck("match_count", OFS_COUNT, 32'd5);
        rdCheck("match_status", OFS_STATUS, 32'h4);
        rdCheck("ctrl_irq_en", OFS_CTRL, IRQ_BUILD ? 32'h4 : 32'h0);
        applyStimulus(1'b1, OFS_COUNT, 32'hAA, 4'h0, 1'b0, rd);
        rdCheck("sel0_no_effect", OFS_COUNT, 32'd5);
        applyStimulus(1'b1, OFS_LIMIT, 32'hDEAD_BEEF, 4'b0101, 1'b0, rd);
        rdCheck("limit_bytemask", OFS_LIMIT, 32'h00AD_00EF);
        wr(OFS_STATUS, 32'h4);
        checkOutput("irq_cleared", 32'(irq), 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0:       dat = 32'h0;
                1:       dat = 32'h1;
                2:       dat = 32'hFFFF_FFFE;
                3:       dat = 32'hFFFF_FFFF;
                4:       dat = 32'($urandom_range(0, 8));
                default: dat = $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), dat,
                          4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), rd);
            idle($urandom_range(0, 3));
        end

        $display("[TB] reset during pending ack");
        wr(OFS_CTRL, 32'h0);
        wr(OFS_STATUS, 32'h7);
        wr(OFS_LIMIT, 32'd3);
        wr(OFS_COUNT, 32'd0);
        wr(OFS_CTRL, 32'h7);
        idle(4);
        checkOutput("irq_before_reset", 32'(irq), 32'(IRQ_BUILD));
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = OFS_COUNT;
        @(posedge clk); #2;
        checkOutput("ack_pending", 32'(bus.wb_ack_o), 32'h1);
        rst_n = 0;
        #1;
        checkOutput("async_rst_ack", 32'(bus.wb_ack_o), 32'h0);
        checkOutput("async_rst_irq", 32'(irq), 32'h0);
        checkOutput("async_rst_dat", bus.wb_dat_o, 32'h0);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        #3 rst_n = 1;
        @(posedge clk); #1;
        rdCheck("post_rst_ctrl",   OFS_CTRL,   32'h0);
        rdCheck("post_rst_count",  OFS_COUNT,  32'h0);
        rdCheck("post_rst_status", OFS_STATUS, 32'h0);
        rdCheck("post_rst_limit",  OFS_LIMIT,  32'hFFFF_FFFF);

        idle(2);
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
